// File: rtl/k_const_seq.sv
// SHA-2 round-constant source: registered K ROM (SHA-256 or SHA-512) with random-access
// reads and an autonomous round sequencer driven by a valid/advance handshake.
module k_const_seq #(
    parameter int unsigned WORD_W  = 32,
    parameter int unsigned ADDR_W  = 7,
    parameter bit          OPT_K15 = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              adv_i,
    input  logic              rd_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              opt_en_i,
    input  logic              iv_control_i,
    input  logic [1:0]        control_i,
    output logic [WORD_W-1:0] k_o,
    output logic              k_valid_o,
    output logic [ADDR_W-1:0] round_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int unsigned ROUNDS = (WORD_W == 64) ? 80 : 64;
    localparam logic [ADDR_W-1:0] LastRound = ADDR_W'(ROUNDS - 1);

    typedef enum logic {StIdle, StRun} state_e;

    state_e            state_q;
    logic [WORD_W-1:0] k_q, k_d;
    logic [ADDR_W-1:0] round_q, fetch_idx;
    logic              valid_q, busy_q, done_q;

    if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
        $error("k_const_seq: WORD_W must be 32 or 64");
    end
    if (2 ** ADDR_W < ROUNDS) begin : g_bad_addr_w
        $error("k_const_seq: ADDR_W too narrow for ROUNDS");
    end

    // Index of the constant that would be loaded at the next edge.
    always_comb begin
        fetch_idx = round_q + 1'b1;
        if (state_q == StIdle) begin
            fetch_idx = start_i ? '0 : addr_i;
        end
    end

    if (WORD_W == 64) begin : g_sha512
        localparam logic [63:0] K512 [80] = '{
            64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
            64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
            64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
            64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
            64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
            64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
            64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
            64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
            64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
            64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
            64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
            64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
            64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
            64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
            64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
            64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
            64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
            64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
            64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
            64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
        };

        always_comb begin
            k_d = '0;
            if (fetch_idx <= LastRound) begin
                k_d = K512[fetch_idx[6:0]];
            end
        end
    end else begin : g_sha256
        localparam logic [31:0] K256 [64] = '{
            32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
            32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
            32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
            32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
            32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
            32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
            32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
            32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
            32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
            32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
            32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
            32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
            32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
            32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
            32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
            32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
        };

        logic patch;

        // K[15] patch qualifiers are taken in the fetch cycle, so they land with the value.
        always_comb begin
            patch = OPT_K15 && (fetch_idx == ADDR_W'(15)) && opt_en_i && iv_control_i &&
                    (control_i == 2'b00);
            k_d = '0;
            if (fetch_idx <= LastRound) begin
                k_d = patch ? 32'hc19bf3f4 : K256[fetch_idx[5:0]];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            k_q     <= '0;
            round_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q <= StRun;
                        k_q     <= k_d;
                        round_q <= '0;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end else if (rd_i) begin
                        k_q     <= k_d;
                        round_q <= addr_i;
                    end
                end
                StRun: begin
                    if (adv_i) begin
                        if (round_q == LastRound) begin
                            state_q <= StIdle;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            k_q     <= k_d;
                            round_q <= fetch_idx;
                        end
                    end
                end
            endcase
        end
    end

    assign k_o       = k_q;
    assign k_valid_o = valid_q;
    assign round_o   = round_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_k_const_seq.sv
// Bench for k_const_seq: a SHA-256 and a SHA-512 instance share stimulus and are checked
// every cycle against a behavioural round-constant model, plus vector tables and sequences.
module tb_k_const_seq;

    localparam logic [31:0] K256 [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [63:0] K512 [80] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    logic        clk = 1'b0;
    logic        rst, start, adv, rd, opt_en, iv_control;
    logic [6:0]  addr;
    logic [1:0]  control;
    logic [31:0] k32;
    logic [63:0] k64;
    logic [6:0]  r32, r64;
    logic        v32, b32, d32, v64, b64, d64;

    always #5 clk = ~clk;

    k_const_seq #(.WORD_W(32), .ADDR_W(7), .OPT_K15(1'b1)) dut32 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .adv_i(adv), .rd_i(rd), .addr_i(addr),
        .opt_en_i(opt_en), .iv_control_i(iv_control), .control_i(control),
        .k_o(k32), .k_valid_o(v32), .round_o(r32), .busy_o(b32), .done_o(d32)
    );

    k_const_seq #(.WORD_W(64), .ADDR_W(7), .OPT_K15(1'b1)) dut64 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .adv_i(adv), .rd_i(rd), .addr_i(addr),
        .opt_en_i(opt_en), .iv_control_i(iv_control), .control_i(control),
        .k_o(k64), .k_valid_o(v64), .round_o(r64), .busy_o(b64), .done_o(d64)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: index 0 is the SHA-256 instance, index 1 the SHA-512 instance.
    logic [63:0] m_k     [2];
    int          m_round [2];
    bit          m_valid [2], m_busy [2], m_done [2];

    function automatic int nrounds(input int w);
        return (w == 0) ? 64 : 80;
    endfunction

    function automatic logic [63:0] kref(input int w, input int idx);
        if (idx >= nrounds(w)) return 64'h0;
        if (w == 0) begin
            if (idx == 15 && opt_en && iv_control && control == 2'b00) return 64'hc19bf3f4;
            return {32'h0, K256[idx[5:0]]};
        end
        return K512[idx[6:0]];
    endfunction

    task automatic model_step();
        for (int w = 0; w < 2; w++) begin
            if (rst) begin
                m_k[w] = '0; m_round[w] = 0; m_valid[w] = 0; m_busy[w] = 0; m_done[w] = 0;
            end else begin
                m_done[w] = 0;
                if (!m_busy[w]) begin
                    if (start) begin
                        m_busy[w] = 1; m_valid[w] = 1; m_round[w] = 0; m_k[w] = kref(w, 0);
                    end else if (rd) begin
                        m_k[w] = kref(w, int'(addr)); m_round[w] = int'(addr);
                    end
                end else if (adv) begin
                    if (m_round[w] == nrounds(w) - 1) begin
                        m_busy[w] = 0; m_valid[w] = 0; m_done[w] = 1;
                    end else begin
                        m_round[w] = m_round[w] + 1;
                        m_k[w] = kref(w, m_round[w]);
                    end
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [73:0] got, input logic [73:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("model32", {32'h0, k32, r32, v32, b32, d32},
              {m_k[0], 7'(m_round[0]), m_valid[0], m_busy[0], m_done[0]});
        check("model64", {k64, r64, v64, b64, d64},
              {m_k[1], 7'(m_round[1]), m_valid[1], m_busy[1], m_done[1]});
    endtask

    task automatic clear_inputs();
        rst = 0; start = 0; adv = 0; rd = 0; addr = '0;
        opt_en = 0; iv_control = 0; control = 2'b00;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    typedef struct {
        bit        start, rd, adv, oe, ivc;
        bit [1:0]  ctl;
        bit [6:0]  addr;
        bit [31:0] k;
        bit [6:0]  round;
        bit        valid, busy;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int cnt32, cnt64, done32, done64, acc;
        logic [63:0] first64, last64;
        bit          oe_s  [3] = '{1'b1, 1'b1, 1'b0};
        bit [1:0]    ctl_s [3] = '{2'b00, 2'b01, 2'b00};
        logic [31:0] k15_s [3] = '{32'hc19bf3f4, 32'hc19bf174, 32'hc19bf174};

        // start rd adv oe ivc ctl addr | k round valid busy
        vecs = '{
            '{0, 1, 0, 0, 0, 2'b00, 7'd63,  32'hc67178f2, 7'd63,  0, 0},
            '{0, 1, 0, 0, 0, 2'b00, 7'd100, 32'h00000000, 7'd100, 0, 0},
            '{0, 1, 0, 1, 1, 2'b00, 7'd15,  32'hc19bf3f4, 7'd15,  0, 0},
            '{0, 1, 0, 1, 1, 2'b01, 7'd15,  32'hc19bf174, 7'd15,  0, 0},
            '{0, 1, 0, 0, 1, 2'b00, 7'd15,  32'hc19bf174, 7'd15,  0, 0},
            '{0, 0, 0, 1, 1, 2'b00, 7'd15,  32'hc19bf174, 7'd15,  0, 0},
            '{0, 0, 1, 0, 0, 2'b00, 7'd3,   32'hc19bf174, 7'd15,  0, 0},
            '{1, 1, 0, 0, 0, 2'b00, 7'd5,   32'h428a2f98, 7'd0,   1, 1},
            '{0, 1, 0, 0, 0, 2'b00, 7'd63,  32'h428a2f98, 7'd0,   1, 1},
            '{0, 0, 1, 0, 0, 2'b00, 7'd0,   32'h71374491, 7'd1,   1, 1}
        };

        clear_inputs();
        rst = 1;
        repeat (2) tick();
        check("reset32", {32'h0, k32, r32, v32, b32, d32}, 74'h0);
        check("reset64", {k64, r64, v64, b64, d64}, 74'h0);
        rst = 0;

        foreach (vecs[i]) begin
            start = vecs[i].start; rd = vecs[i].rd; adv = vecs[i].adv; addr = vecs[i].addr;
            opt_en = vecs[i].oe; iv_control = vecs[i].ivc; control = vecs[i].ctl;
            tick();
            check($sformatf("vec%0d", i), {k32, r32, v32, b32, d32},
                  {vecs[i].k, vecs[i].round, vecs[i].valid, vecs[i].busy, 1'b0});
        end

        // Full sequences with adv held high on both widths.
        do_reset();
        start = 1; adv = 1;
        tick();
        start = 0;
        check("latency32", {k32, v32}, {32'h428a2f98, 1'b1});
        check("latency64", {k64, v64}, {64'h428a2f98d728ae22, 1'b1});
        cnt32 = int'(v32); cnt64 = int'(v64); done32 = 0; done64 = 0;
        first64 = k64; last64 = '0;
        for (int i = 0; i < 90; i++) begin
            tick();
            cnt32 += int'(v32); cnt64 += int'(v64);
            done32 += int'(d32); done64 += int'(d64);
            if (v64 && r64 == 7'd79) last64 = k64;
        end
        check("valid_count32", 74'(cnt32), 74'd64);
        check("valid_count64", 74'(cnt64), 74'd80);
        check("done_count32", 74'(done32), 74'd1);
        check("done_count64", 74'(done64), 74'd1);
        check("first64", first64, 64'h428a2f98d728ae22);
        check("last64", last64, 64'h6c44198c4a475817);

        // Back-to-back: start accepted in the done cycle.
        do_reset();
        start = 1; adv = 1;
        tick();
        start = 0;
        repeat (64) tick();
        check("done_pulse", {d32, b32, v32, k32, r32}, {3'b100, 32'hc67178f2, 7'd63});
        start = 1;
        tick();
        start = 0;
        check("back_to_back", {v32, k32, r32}, {1'b1, 32'h428a2f98, 7'd0});

        // Stall at round 10.
        do_reset();
        start = 1;
        tick();
        start = 0; adv = 1; acc = 0;
        for (int i = 0; i < 10; i++) begin
            if (v32 && adv) acc++;
            tick();
        end
        adv = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold", {k32, r32, v32}, {32'h243185be, 7'd10, 1'b1});
        end
        adv = 1;
        if (v32) acc++;
        tick();
        check("stall_resume", {k32, r32}, {32'h550c7dc3, 7'd11});
        for (int i = 0; i < 100 && !d32; i++) begin
            if (v32 && adv) acc++;
            tick();
        end
        check("stall_accepts", 74'(acc), 74'd64);
        check("stall_done", 74'(d32), 74'd1);

        // K[15] patch inside a sequence.
        for (int s = 0; s < 3; s++) begin
            do_reset();
            opt_en = oe_s[s]; iv_control = 1; control = ctl_s[s];
            start = 1;
            tick();
            start = 0; adv = 1;
            repeat (15) tick();
            check($sformatf("seq_k15_%0d", s), {k32, r32}, {k15_s[s], 7'd15});
            adv = 0; control = 2'b11; opt_en = ~opt_en;
            tick();
            check($sformatf("seq_k15_hold_%0d", s), k32, k15_s[s]);
        end

        // Reset mid-sequence at round 30.
        do_reset();
        start = 1;
        tick();
        start = 0; adv = 1;
        repeat (30) tick();
        check("pre_reset_round", r32, 7'd30);
        rst = 1;
        tick();
        rst = 0;
        check("mid_reset32", {32'h0, k32, r32, v32, b32, d32}, 74'h0);
        check("mid_reset64", {k64, r64, v64, b64, d64}, 74'h0);
        done32 = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            done32 += int'(d32);
        end
        check("no_done_after_reset", 74'(done32), 74'd0);
        start = 1;
        tick();
        start = 0;
        check("restart", {k32, r32, v32}, {32'h428a2f98, 7'd0, 1'b1});

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 299) == 0);
            start      = ($urandom_range(0, 7) == 0);
            adv        = ($urandom_range(0, 3) != 0);
            rd         = ($urandom_range(0, 3) == 0);
            addr       = ($urandom_range(0, 3) == 0) ? 7'd15 : 7'($urandom_range(0, 127));
            opt_en     = 1'($urandom);
            iv_control = 1'($urandom);
            control    = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/k_const_seq.md
Name: k_const_seq

Overview:
- Parametrised SHA-2 round-constant source and sequencer; next generation of the single-table K ROM.
- Holds the SHA-256 table (64 x 32-bit) or the SHA-512 table (80 x 64-bit), selected at elaboration.
- Two access methods:
  - Random-access read: one-cycle registered lookup.
  - Autonomous round sequencer: streams K[0..ROUNDS-1] to the compression datapath under a valid/advance handshake, with a start/busy/done protocol.

Parameters:
- WORD_W, 32, constant width. 32 selects the SHA-256 table; 64 selects the SHA-512 table. Any other value is an elaboration error.
- ROUNDS, derived (localparam), 64 when WORD_W=32, 80 when WORD_W=64.
- ADDR_W, 7, address/round-index width. Must be at least clog2(ROUNDS).
- OPT_K15, 1, 1 enables the K[15] precomputation patch (WORD_W=32 only). 0 removes it.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, begin a sequence; sampled only when idle.
- adv, input, 1, consumer accepts the current k_out; advance to the next round.
- rd, input, 1, random-access read request; sampled only when idle.
- addr, input, ADDR_W, random-access index.
- opt_en, input, 1, patch enable.
- iv_control, input, 1, patch qualifier.
- control, input, 2, patch qualifier; the patch applies only when control=2'b00.
- k_out, output, WORD_W, registered constant.
- k_valid, output, 1, k_out holds the sequencer's current round constant.
- round, output, ADDR_W, index of the constant currently on k_out.
- busy, output, 1, sequencer active.
- done, output, 1, one-cycle pulse after the last round is accepted.

Behaviour:
- Reset (rst=1 at an edge):
  - k_out=0, k_valid=0, round=0, busy=0, done=0. State goes to IDLE.
  - Reset overrides every other input in the same cycle, including mid-sequence; the sequence is abandoned and no done pulse is issued.
- States: IDLE and RUN.
- IDLE:
  - done is 0 except in the cycle immediately following completion.
  - start=1: next edge goes to RUN with round=0, k_out=K[0], k_valid=1, busy=1. Latency start→first valid is 1 cycle.
  - rd=1 with start=0: next edge k_out=K[addr], round=addr, k_valid stays 0. If addr>=ROUNDS, k_out=0.
  - start=1 and rd=1 in the same cycle: start wins; rd is dropped.
  - Neither start nor rd: k_out holds its value.
- RUN:
  - adv=0: k_out, round and k_valid hold (stall, any length).
  - adv=1 with round<ROUNDS-1: next edge round+1, k_out=K[round+1], k_valid=1. Full throughput is one constant per cycle.
  - adv=1 with round=ROUNDS-1: next edge returns to IDLE with k_valid=0, busy=0, done=1 for exactly one cycle. k_out and round hold their last values.
  - start and rd are ignored while in RUN.
- adv while in IDLE is ignored.
- K[15] patch (OPT_K15=1 and WORD_W=32 only):
  - When a fetch of index 15 happens with opt_en=1, iv_control=1 and control=2'b00, the loaded value is 32'hc19bf3f4 instead of 32'hc19bf174.
  - The qualifiers are sampled in the cycle the fetch is issued (the cycle before K[15] appears). Later changes do not alter a loaded value.
  - The rule applies identically to sequencer and random-access fetches.
  - With WORD_W=64 or OPT_K15=0, the table value is always used.
- Table contents are the FIPS 180-4 constants, stored as registered ROM; no combinational path from any input to k_out.
- Back-to-back sequences: start is accepted in the done cycle, since the block is already IDLE. K[0] then appears on the next edge.

Test Plan:
- Reset then start pulse, adv held 1, WORD_W=32:
  - k_valid rises 1 cycle after start.
  - k_out sequence: 428a2f98, 71374491, ..., c67178f2.
  - 64 valid cycles, then done=1 for exactly 1 cycle; busy falls with done.
- WORD_W=64 sequence:
  - First k_out=428a2f98d728ae22, last (round 79) 6c44198c4a475817.
  - 80 valid cycles, then done.
- K[15] patch, WORD_W=32:
  - opt_en=1, iv_control=1, control=00 → round 15 gives c19bf3f4.
  - Repeat with control=01 → c19bf174.
  - Repeat with opt_en=0 → c19bf174.
  - Random access to addr=15 gives the same results.
- Stalls: adv deasserted for 3 cycles at round 10 → k_out holds 243185be and round holds 10; resume gives 550c7dc3. Total accepted count is still 64.
- Random access in IDLE:
  - rd, addr=63 → next cycle k_out=c67178f2, k_valid=0.
  - addr=100 → k_out=0.
  - rd and start together → sequence starts, k_out=428a2f98.
  - rd during RUN → ignored.
- Reset mid-sequence at round 30: all outputs 0 on the next edge, no done pulse; a following start restarts at K[0].
